huff_out_sched: RTL and testbench

Output-phase controller for the Huffman encoder. It receives the finished 8-symbol code table from the tree builder, selects a fixed 5-symbol message by mode, and serialises those symbols' codewords MSB-first onto the single-bit `out_code` stream under `out_valid`. The block sits between the code-table generator and the top-level output ports, and it owns all output timing.

---
 rtl/huff_out_sched.sv | 216 +++++++++++++++++++++
 tb/tb_huff_out_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_out_sched.sv
// huff_out_sched -- output-phase controller of the Huffman encoder.
//
// Takes the finished code table from the tree builder and picks a fixed
// 5-symbol message by mode. It then shifts those symbols' codewords out
// MSB-first, one bit per cycle, on out_code qualified by out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   tbl_valid  one-cycle pulse: tbl_mode/tbl_len/tbl_code valid this cycle
//   tbl_mode   0: I L O V E (4,5,6,7,3)   1: I C L A B (4,2,5,0,1)
//   tbl_len    NSYM x LEN_W code lengths, symbol k at [LEN_W*k +: LEN_W]
//   tbl_code   NSYM x CODE_W codewords, right-aligned, symbol k at [CODE_W*k +: CODE_W]
//   busy       high from the cycle after accept until the cycle after done
//   out_valid  a code bit is on out_code
//   out_code   serial code bit, 0 when out_valid is 0
//   done       one-cycle pulse in the cycle after the last bit
//
// All outputs are registered. The FSM works one cycle ahead of the pins,
// so a table sampled at edge T gives its first bit in cycle T+1.
module huff_out_sched #(
   parameter int NSYM    = 8,
   parameter int LEN_W   = 3,
   parameter int CODE_W  = 7,
   parameter int MSG_LEN = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tbl_valid,
   input  logic                     tbl_mode,
   input  logic [NSYM*LEN_W-1:0]    tbl_len,
   input  logic [NSYM*CODE_W-1:0]   tbl_code,
   output logic                     busy,
   output logic                     out_valid,
   output logic                     out_code,
   output logic                     done
);

   localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

   typedef enum logic [1:0] {IDLE, SEND, SKIP, FIN} state_t;

   // Table index of the symbol at message position pos.
   function automatic int msg_sym(input logic mode, input int pos);
      int s;
      s = 0;
      if (!mode) begin
         case (pos)
            0:       s = 4;
            1:       s = 5;
            2:       s = 6;
            3:       s = 7;
            default: s = 3;
         endcase
      end else begin
         case (pos)
            0:       s = 4;
            1:       s = 2;
            2:       s = 5;
            3:       s = 0;
            default: s = 1;
         endcase
      end
      return s;
   endfunction

   // Message-ordered view of the incoming table. Only the selected
   // entries are latched; together they carry both table and mode.
   logic [LEN_W-1:0]  in_len  [MSG_LEN];
   logic [CODE_W-1:0] in_code [MSG_LEN];

   for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_sel
      localparam int S0 = msg_sym(1'b0, gi);
      localparam int S1 = msg_sym(1'b1, gi);
      assign in_len[gi]  = tbl_mode ? tbl_len[S1*LEN_W +: LEN_W]
                                    : tbl_len[S0*LEN_W +: LEN_W];
      assign in_code[gi] = tbl_mode ? tbl_code[S1*CODE_W +: CODE_W]
                                    : tbl_code[S0*CODE_W +: CODE_W];
   end

   state_t            state_reg, state_next;
   logic [PTR_W-1:0]  sym_reg, sym_next;
   logic [LEN_W-1:0]  bit_reg, bit_next;
   logic [LEN_W-1:0]  len_reg  [MSG_LEN];
   logic [CODE_W-1:0] code_reg [MSG_LEN];
   logic              busy_reg, busy_next;
   logic              valid_reg, valid_next;
   logic              code_bit_reg, code_bit_next;
   logic              done_reg, done_next;
   logic              load;

   logic              in_all_zero;
   logic [PTR_W-1:0]  skip_sym;
   logic [PTR_W-1:0]  cur_sym, nxt_sym;
   logic [LEN_W-1:0]  cur_bit;
   logic              nxt_found;

   // in_all_zero: the incoming message has no bits at all.
   // skip_sym: first non-empty symbol at or after sym_reg. SKIP is only
   // entered when such a symbol exists, so it always resolves.
   always_comb begin
      in_all_zero = 1'b1;
      skip_sym    = sym_reg;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (in_len[i] != '0) in_all_zero = 1'b0;
      end
      for (int i = MSG_LEN - 1; i >= 0; i--) begin
         if (PTR_W'(i) >= sym_reg && len_reg[i] != '0) skip_sym = PTR_W'(i);
      end
   end

   always_comb begin
      state_next    = state_reg;
      sym_next      = sym_reg;
      bit_next      = bit_reg;
      load          = 1'b0;
      busy_next     = (state_reg != IDLE);
      valid_next    = 1'b0;
      code_bit_next = 1'b0;
      done_next     = 1'b0;
      cur_sym       = sym_reg;
      cur_bit       = bit_reg;
      nxt_sym       = '0;
      nxt_found     = 1'b0;

      case (state_reg)
         IDLE: begin
            // busy_reg still shows the FIN cycle, so a restart is only
            // taken once busy has visibly dropped.
            if (tbl_valid && !busy_reg) begin
               load     = 1'b1;
               sym_next = '0;
               if (in_all_zero) begin
                  state_next = FIN;
               end else if (in_len[0] == '0) begin
                  state_next = SKIP;
               end else begin
                  bit_next   = in_len[0] - LEN_W'(1);
                  state_next = SEND;
               end
            end
         end
         SEND, SKIP: begin
            // SKIP jumps straight to the first bit of the next non-empty
            // symbol, so empty symbols never cost a cycle.
            if (state_reg == SKIP) begin
               cur_sym = skip_sym;
               cur_bit = len_reg[skip_sym] - LEN_W'(1);
            end
            valid_next    = 1'b1;
            code_bit_next = code_reg[cur_sym][cur_bit];
            if (cur_bit == '0) begin
               // Descending scan leaves the lowest later non-empty symbol.
               for (int i = MSG_LEN - 1; i >= 0; i--) begin
                  if (PTR_W'(i) > cur_sym && len_reg[i] != '0) begin
                     nxt_sym   = PTR_W'(i);
                     nxt_found = 1'b1;
                  end
               end
               if (nxt_found) begin
                  sym_next   = nxt_sym;
                  bit_next   = len_reg[nxt_sym] - LEN_W'(1);
                  state_next = SEND;
               end else begin
                  state_next = FIN;
               end
            end else begin
               sym_next   = cur_sym;
               bit_next   = cur_bit - LEN_W'(1);
               state_next = SEND;
            end
         end
         FIN: begin
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         sym_reg      <= '0;
         bit_reg      <= '0;
         busy_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         code_bit_reg <= 1'b0;
         done_reg     <= 1'b0;
         for (int i = 0; i < MSG_LEN; i++) begin
            len_reg[i]  <= '0;
            code_reg[i] <= '0;
         end
      end else begin
         state_reg    <= state_next;
         sym_reg      <= sym_next;
         bit_reg      <= bit_next;
         busy_reg     <= busy_next;
         valid_reg    <= valid_next;
         code_bit_reg <= code_bit_next;
         done_reg     <= done_next;
         if (load) begin
            for (int i = 0; i < MSG_LEN; i++) begin
               len_reg[i]  <= in_len[i];
               code_reg[i] <= in_code[i];
            end
         end
      end
   end

   assign busy      = busy_reg;
   assign out_valid = valid_reg;
   assign out_code  = code_bit_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_huff_out_sched.sv
// tb_huff_out_sched -- directed bench for huff_out_sched.
//
// A message-level model turns every accepted table into expected
// per-cycle out_valid/out_code/done/busy values. A single compare process
// checks the DUT against it on every cycle. Each scenario also checks the
// captured bit stream, bit count and done latency against hand-written
// literals.
module tb_huff_out_sched;

   localparam int NSYM    = 8;
   localparam int LEN_W   = 3;
   localparam int CODE_W  = 7;
   localparam int MSG_LEN = 5;
   localparam int NCYC    = 4096;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   tbl_valid = 1'b0;
   logic                   tbl_mode = 1'b0;
   logic [NSYM*LEN_W-1:0]  tbl_len = '0;
   logic [NSYM*CODE_W-1:0] tbl_code = '0;
   logic                   busy, out_valid, out_code, done;

   always #5 clk = ~clk;

   huff_out_sched #(.NSYM(NSYM), .LEN_W(LEN_W), .CODE_W(CODE_W), .MSG_LEN(MSG_LEN)) dut (
      .clk(clk), .rst(rst), .tbl_valid(tbl_valid), .tbl_mode(tbl_mode),
      .tbl_len(tbl_len), .tbl_code(tbl_code),
      .busy(busy), .out_valid(out_valid), .out_code(out_code), .done(done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   bit exp_valid [NCYC];
   bit exp_code  [NCYC];
   bit exp_done  [NCYC];
   bit exp_busy  [NCYC];
   int last_busy = -10;
   int acc_edge  = -1;
   int msg_tbl [2][MSG_LEN] = '{'{4, 5, 6, 7, 3}, '{4, 2, 5, 0, 1}};

   // Common table, index order A B C E I L O V.
   int c_len  [NSYM] = '{3, 4, 2, 4, 2, 3, 4, 4};
   int c_code [NSYM] = '{5, 12, 1, 13, 0, 4, 14, 15};

   logic [34:0] cap;
   int          cap_n;
   int          done_cyc;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Model: sample inputs at each rising edge and project the message.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         for (int i = cyc; i < NCYC; i++) begin
            exp_valid[i] = 1'b0; exp_code[i] = 1'b0;
            exp_done[i]  = 1'b0; exp_busy[i] = 1'b0;
         end
         last_busy = cyc - 1;
      end else if (tbl_valid && (cyc - 1) > last_busy) begin
         int n;
         n = 0;
         for (int p = 0; p < MSG_LEN; p++) begin
            int          idx, len;
            logic [CODE_W-1:0] code;
            idx  = msg_tbl[tbl_mode][p];
            len  = int'(tbl_len[idx*LEN_W +: LEN_W]);
            code = tbl_code[idx*CODE_W +: CODE_W];
            for (int b = len - 1; b >= 0; b--) begin
               if (cyc + 1 + n < NCYC) begin
                  exp_valid[cyc + 1 + n] = 1'b1;
                  exp_code[cyc + 1 + n]  = code[b];
               end
               n++;
            end
         end
         if (cyc + 1 + n < NCYC) exp_done[cyc + 1 + n] = 1'b1;
         for (int k = 1; k <= n + 1; k++) begin
            if (cyc + k < NCYC) exp_busy[cyc + k] = 1'b1;
         end
         last_busy = cyc + 1 + n;
         acc_edge  = cyc;
      end
   end

   // Compare process: mid-cycle check of every output.
   initial forever begin
      @(negedge clk);
      if (cyc > 0 && cyc < NCYC) begin
         check("out_valid", 64'(out_valid), 64'(exp_valid[cyc]));
         check("out_code",  64'(out_code),  64'(exp_code[cyc]));
         check("done",      64'(done),      64'(exp_done[cyc]));
         check("busy",      64'(busy),      64'(exp_busy[cyc]));
         if (out_valid === 1'b1) begin
            cap = {cap[33:0], out_code};
            cap_n++;
         end
         if (done === 1'b1) done_cyc = cyc;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic reset_cap();
      cap = '0; cap_n = 0; done_cyc = -1;
   endtask

   task automatic drive_tbl(input logic mode, input int lens[NSYM], input int codes[NSYM]);
      tbl_mode = mode;
      for (int k = 0; k < NSYM; k++) begin
         tbl_len[k*LEN_W +: LEN_W]    = LEN_W'(lens[k]);
         tbl_code[k*CODE_W +: CODE_W] = CODE_W'(codes[k]);
      end
   endtask

   // One-cycle table pulse; buses are scrambled afterwards so a design
   // that reads them live cannot reproduce the stream.
   task automatic pulse_tbl(input logic mode, input int lens[NSYM], input int codes[NSYM]);
      drive_tbl(mode, lens, codes);
      tbl_valid = 1'b1;
      step();
      tbl_valid = 1'b0;
      tbl_mode  = 1'($urandom);
      tbl_len   = NSYM*LEN_W'($urandom);
      tbl_code  = {$urandom, $urandom};
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      step();
      while (busy === 1'b1 && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) check({nm, "_idle_timeout"}, 64'(1), 64'(0));
      step();
   endtask

   task automatic check_msg(input string nm, input logic [34:0] lit, input int nbits);
      check({nm, "_stream"},   64'(cap), 64'(lit));
      check({nm, "_bitcount"}, 64'(cap_n), 64'(nbits));
      check({nm, "_done_lat"}, 64'(done_cyc - acc_edge), 64'(nbits + 1));
   endtask

   initial begin
      int l3[NSYM];
      int l4[NSYM];
      int l0[NSYM];
      int k;

      reset_cap();
      repeat (3) step();
      rst = 1'b0;
      check("reset_busy",      64'(busy),      64'(0));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_out_code",  64'(out_code),  64'(0));
      check("reset_done",      64'(done),      64'(0));
      step();

      // Mode 0; a table pulsed in the done cycle must be ignored.
      reset_cap();
      pulse_tbl(1'b0, c_len, c_code);
      k = 0;
      while (done !== 1'b1 && k < 60) begin step(); k++; end
      if (k >= 60) check("mode0_done_timeout", 64'(1), 64'(0));
      drive_tbl(1'b1, c_len, c_code);
      tbl_valid = 1'b1;
      step();
      tbl_valid = 1'b0;
      repeat (3) step();
      check("fin_restart_ignored", 64'(busy), 64'(0));
      check_msg("mode0", 35'b00100111011111101, 17);

      // Mode 1.
      reset_cap();
      pulse_tbl(1'b1, c_len, c_code);
      wait_idle("mode1");
      check_msg("mode1", 35'b00011001011100, 14);

      // C, L, A empty, mode 1: I then B with no bubble.
      l3 = c_len; l3[2] = 0; l3[5] = 0; l3[0] = 0;
      reset_cap();
      pulse_tbl(1'b1, l3, c_code);
      wait_idle("skip_mid");
      check_msg("skip_mid", 35'b001100, 6);

      // I empty, mode 0: message starts on a skipped symbol.
      l4 = c_len; l4[4] = 0;
      reset_cap();
      pulse_tbl(1'b0, l4, c_code);
      wait_idle("skip_first");
      check_msg("skip_first", 35'b100111011111101, 15);

      // All lengths zero.
      l0 = '{0, 0, 0, 0, 0, 0, 0, 0};
      reset_cap();
      pulse_tbl(1'b0, l0, c_code);
      wait_idle("zero");
      check_msg("zero", 35'b0, 0);

      // Mid-stream table pulse is ignored; restart after busy falls.
      reset_cap();
      pulse_tbl(1'b0, c_len, c_code);
      repeat (5) step();
      pulse_tbl(1'b1, l0, c_code);
      wait_idle("midpulse");
      check_msg("midpulse", 35'b00100111011111101, 17);
      reset_cap();
      pulse_tbl(1'b1, c_len, c_code);
      wait_idle("after_mid");
      check_msg("after_mid", 35'b00011001011100, 14);

      // Reset at bit 8 of the mode-0 message, then a full restart.
      reset_cap();
      pulse_tbl(1'b0, c_len, c_code);
      k = 0;
      while (cap_n < 9 && k < 40) begin step(); k++; end
      if (k >= 40) check("rst_wait_timeout", 64'(1), 64'(0));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_busy",      64'(busy),      64'(0));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_out_code",  64'(out_code),  64'(0));
      check("midrst_done",      64'(done),      64'(0));
      check("midrst_partial",   64'(cap),       64'(9'b001001110));
      repeat (3) step();
      check("midrst_no_resume", 64'(busy),      64'(0));
      reset_cap();
      pulse_tbl(1'b0, c_len, c_code);
      wait_idle("post_rst");
      check_msg("post_rst", 35'b00100111011111101, 17);

      // Reset and table in the same cycle: nothing is latched.
      drive_tbl(1'b0, c_len, c_code);
      rst = 1'b1;
      tbl_valid = 1'b1;
      step();
      rst = 1'b0;
      tbl_valid = 1'b0;
      repeat (3) step();
      check("rst_wins_busy",  64'(busy),      64'(0));
      check("rst_wins_valid", 64'(out_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
